gmii_rx_pkt134_packer: RTL and testbench

GMII_RX_PKT134_PACKER -- requirements
Module: gmii_rx_pkt134_packer

---
 rtl/gmii_rx_pkt134_packer_if.sv | 21 ++
 rtl/gmii_rx_pkt134_packer.sv | 183 ++++++++++++++++++
 tb/tb_gmii_rx_pkt134_packer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_pkt134_packer_if.sv
// rtl/gmii_rx_pkt134_packer_if.sv - GMII receive input and 134-bit packet word output bundle.
// slave: packer side; master: MAC/PHY driver and packet sink side.
interface gmii_rx_pkt134_packer_if;
  logic         gmii_rx_dv;
  logic         gmii_rx_er;
  logic [7:0]   gmii_rxd;
  logic         pktData_valid;
  logic [133:0] pktData;
  logic [15:0]  pkt_cnt;
  logic [15:0]  drop_cnt;

  modport slave (
    input  gmii_rx_dv, gmii_rx_er, gmii_rxd,
    output pktData_valid, pktData, pkt_cnt, drop_cnt
  );

  modport master (
    output gmii_rx_dv, gmii_rx_er, gmii_rxd,
    input  pktData_valid, pktData, pkt_cnt, drop_cnt
  );
endinterface

// File: rtl/gmii_rx_pkt134_packer.sv
// rtl/gmii_rx_pkt134_packer.sv - GMII receive packer into 134-bit tagged words.
// Frames are buffered and only released once committed, so bad frames never leave.
module gmii_rx_pkt134_packer #(
  parameter int BUF_AW  = 7,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input logic                      clk,
  input logic                      rst,
  gmii_rx_pkt134_packer_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [10:0]       MIN_LEN_W = 11'(MIN_LEN);
  localparam logic [10:0]       LEN_OVF   = 11'(MAX_LEN + 1);
  localparam logic [BUF_AW-1:0] PTR_ONE   = 1;

  logic [1:0]        state_q, state_d;
  logic [127:0]      word_q, word_d;
  logic [3:0]        idx_q, idx_d;
  logic [10:0]       len_q, len_d, len_inc;
  logic [127:0]      stage_q, stage_d;
  logic              stage_vld_q, stage_vld_d;
  logic              head_q, head_d;
  logic [BUF_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_AW-1:0] commit_q, commit_d;
  logic [BUF_AW-1:0] rd_ptr_q;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic              we;
  logic [133:0]      wr_data;
  logic              drop;
  logic              full;
  logic              rd_en;

  logic [133:0]      mem_q [0:(1<<BUF_AW)-1];
  logic [133:0]      rd_data_q;
  logic              rd_vld_q;
  logic [133:0]      pkt_q;
  logic              pkt_vld_q;

  assign full    = (wr_ptr_q + PTR_ONE) == rd_ptr_q;
  assign rd_en   = rd_ptr_q != commit_q;
  assign len_inc = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    len_d       = len_q;
    stage_d     = stage_q;
    stage_vld_d = stage_vld_q;
    head_d      = head_q;
    wr_ptr_d    = wr_ptr_q;
    commit_d    = commit_q;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    we          = 1'b0;
    wr_data     = '0;
    drop        = 1'b0;

    case (state_q)
      S_IDLE, S_PRE: begin
        if (bus.gmii_rx_dv && bus.gmii_rxd == 8'hD5) begin
          state_d     = S_DATA;
          word_d      = '0;
          idx_d       = 4'd0;
          len_d       = 11'd0;
          stage_vld_d = 1'b0;
          head_d      = 1'b1;
        end else if (bus.gmii_rx_dv && bus.gmii_rxd == 8'h55) begin
          state_d = S_PRE;
        end else if (state_q == S_PRE) begin
          state_d = S_IDLE;
        end else if (bus.gmii_rx_dv) begin
          state_d = S_DROP;
        end
      end

      S_DATA: begin
        if (bus.gmii_rx_dv) begin
          len_d = len_inc;
          // The staged word is only known not to be the tail once another byte shows up.
          if (stage_vld_q) begin
            we          = 1'b1;
            wr_data     = {(head_q ? 2'b01 : 2'b00), 4'hF, stage_q};
            wr_ptr_d    = wr_ptr_q + PTR_ONE;
            head_d      = 1'b0;
            stage_vld_d = 1'b0;
          end
          word_d[{~idx_q, 3'b000} +: 8] = bus.gmii_rxd;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'hF) begin
            stage_d     = word_d;
            stage_vld_d = 1'b1;
            word_d      = '0;
          end
          if (bus.gmii_rx_er || len_inc == LEN_OVF || (stage_vld_q && full)) begin
            drop = 1'b1;
          end
        end else begin
          if (len_q < MIN_LEN_W || full) begin
            drop = 1'b1;
          end else begin
            we       = 1'b1;
            wr_data  = stage_vld_q ? {2'b10, 4'hF, stage_q}
                                   : {2'b10, idx_q - 4'd1, word_q};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            commit_d = wr_ptr_q + PTR_ONE;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            stage_vld_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end

      default: begin
        if (!bus.gmii_rx_dv) state_d = S_IDLE;
      end
    endcase

    // Rewinding to the last commit point discards every word of the frame in one step.
    if (drop) begin
      we          = 1'b0;
      wr_ptr_d    = commit_q;
      drop_cnt_d  = drop_cnt_q + 16'd1;
      stage_vld_d = 1'b0;
      state_d     = bus.gmii_rx_dv ? S_DROP : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_DROP;
      word_q      <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      head_q      <= 1'b0;
      wr_ptr_q    <= '0;
      commit_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      rd_vld_q    <= 1'b0;
      pkt_q       <= '0;
      pkt_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      commit_q    <= commit_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      rd_vld_q    <= rd_en;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      pkt_vld_q   <= rd_vld_q;
      pkt_q       <= rd_vld_q ? rd_data_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[wr_ptr_q] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_ptr_q];
  end

  assign bus.pktData_valid = pkt_vld_q;
  assign bus.pktData       = pkt_q;
  assign bus.pkt_cnt       = pkt_cnt_q;
  assign bus.drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_gmii_rx_pkt134_packer.sv
// tb/tb_gmii_rx_pkt134_packer.sv - bench for the GMII receive packer.
module tb_gmii_rx_pkt134_packer;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic clk = 1'b0;
  logic rst;
  logic dv, er;
  logic [7:0] rxd;
  int sel;
  int cyc = 0;
  int dv0_cyc;
  int checks = 0;
  int errors = 0;

  logic [7:0]   fb[$];
  logic [133:0] got_q[$];
  int           got_t[$];
  logic [133:0] exp_q[$];
  logic [15:0]  exp_pkt[2];
  logic [15:0]  exp_drop[2];

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gmii_rx_pkt134_packer_if bus_a();
  gmii_rx_pkt134_packer_if bus_b();

  assign bus_a.gmii_rx_dv = (sel == 0) && dv;
  assign bus_a.gmii_rx_er = (sel == 0) && er;
  assign bus_a.gmii_rxd   = (sel == 0) ? rxd : 8'h00;
  assign bus_b.gmii_rx_dv = (sel == 1) && dv;
  assign bus_b.gmii_rx_er = (sel == 1) && er;
  assign bus_b.gmii_rxd   = (sel == 1) ? rxd : 8'h00;

  gmii_rx_pkt134_packer dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  gmii_rx_pkt134_packer #(.BUF_AW(5)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.pktData_valid) begin
      got_q.push_back(bus_a.pktData);
      got_t.push_back(cyc);
    end else if (!rst) chk("a_idle_zero", bus_a.pktData, '0);
    if (bus_b.pktData_valid) begin
      got_q.push_back(bus_b.pktData);
      got_t.push_back(cyc);
    end else if (!rst) chk("b_idle_zero", bus_b.pktData, '0);
  end

  task automatic make_inc(input int len);
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'(i));
  endtask

  task automatic make_rand(input int len);
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
  endtask

  task automatic drive(input logic d, input logic e, input logic [7:0] b);
    @(posedge clk);
    #1;
    dv = d; er = e; rxd = b;
  endtask

  task automatic send_frame(input int s, input int er_at, input int rst_at);
    sel = s;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < fb.size(); i++) begin
      drive(1'b1, i == er_at, fb[i]);
      rst = (rst_at >= 0) && (i >= rst_at) && (i < rst_at + 2);
    end
    drive(1'b0, 1'b0, 8'h00);
    dv0_cyc = cyc;
  endtask

  // Expected output derived from frame contents: 16-byte big-endian words, first tagged head, last tagged tail.
  task automatic model_frame(input int s, input bit err);
    int len = fb.size();
    int nw = (len + 15) / 16;
    int cap = (s == 0) ? 127 : 31;
    logic [127:0] d;
    logic [1:0] tag;
    logic [3:0] vb;
    if (err || len < MIN_LEN || len > MAX_LEN || nw > cap) begin
      exp_drop[s] = exp_drop[s] + 16'd1;
    end else begin
      exp_pkt[s] = exp_pkt[s] + 16'd1;
      for (int k = 0; k < nw; k++) begin
        d = '0;
        for (int b = 0; b < 16; b++)
          if (16 * k + b < len) d[127 - 8 * b -: 8] = fb[16 * k + b];
        tag = (k == nw - 1) ? 2'b10 : (k == 0) ? 2'b01 : 2'b00;
        vb  = (k == nw - 1) ? 4'((len - 1) % 16) : 4'hF;
        exp_q.push_back({tag, vb, d});
      end
    end
  endtask

  task automatic check_out(input string tag, input bit lat);
    repeat (130) @(posedge clk);
    #2;
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    if (lat && exp_q.size() > 0 && got_t.size() > 0)
      chk({tag, "_latency"}, got_t[0] - dv0_cyc, 3);
    chk({tag, "_pkt_cnt_a"}, bus_a.pkt_cnt, exp_pkt[0]);
    chk({tag, "_drop_cnt_a"}, bus_a.drop_cnt, exp_drop[0]);
    chk({tag, "_pkt_cnt_b"}, bus_b.pkt_cnt, exp_pkt[1]);
    chk({tag, "_drop_cnt_b"}, bus_b.drop_cnt, exp_drop[1]);
    got_q.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input string tag, input int s, input int er_at);
    send_frame(s, er_at, -1);
    model_frame(s, er_at >= 0);
    check_out(tag, 1'b1);
  endtask

  initial begin
    logic [133:0] w;
    int len, er_at;
    rst = 1'b1; dv = 1'b0; er = 1'b0; rxd = 8'h00; sel = 0;
    exp_pkt[0] = 0; exp_pkt[1] = 0; exp_drop[0] = 0; exp_drop[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_a", bus_a.pktData_valid, 0);
    chk("rst_data_a", bus_a.pktData, 0);
    chk("rst_pkt_a", bus_a.pkt_cnt, 0);
    chk("rst_drop_a", bus_a.drop_cnt, 0);
    chk("rst_valid_b", bus_b.pktData_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    make_inc(64);
    send_frame(0, -1, -1);
    model_frame(0, 1'b0);
    repeat (20) @(posedge clk);
    w = {2'b01, 4'hF, 128'h000102030405060708090a0b0c0d0e0f};
    chk("s64_head_lit", got_q[0], w);
    w = {2'b10, 4'hF, 128'h303132333435363738393a3b3c3d3e3f};
    chk("s64_tail_lit", got_q[3], w);
    check_out("s64", 1'b1);

    make_inc(65);
    send_frame(0, -1, -1);
    model_frame(0, 1'b0);
    repeat (20) @(posedge clk);
    w = {2'b10, 4'h0, 8'h40, 120'h0};
    chk("s65_tail_lit", got_q[4], w);
    check_out("s65", 1'b1);

    make_rand(100);
    run_frame("er30", 0, 29);
    make_inc(64);
    run_frame("after_er", 0, -1);

    make_inc(63);
    run_frame("len63", 0, -1);
    make_rand(1519);
    run_frame("len1519", 0, -1);
    make_rand(1518);
    send_frame(0, -1, -1);
    model_frame(0, 1'b0);
    repeat (110) @(posedge clk);
    w = got_q[94];
    chk("len1518_tail_vld", w[131:128], 4'hD);
    check_out("len1518", 1'b1);

    make_rand(1518);
    run_frame("ovf_b", 1, -1);
    make_inc(64);
    run_frame("b_after_ovf", 1, -1);

    make_rand(1518);
    send_frame(0, -1, -1);
    model_frame(0, 1'b0);
    make_rand(64);
    send_frame(0, -1, -1);
    model_frame(0, 1'b0);
    repeat (130) @(posedge clk);
    chk("b2b_contig", got_t[got_t.size() - 1] - got_t[0], exp_q.size() - 1);
    check_out("b2b", 1'b0);

    for (int n = 0; n < 20; n++) begin
      len = $urandom_range(40, 160);
      er_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      make_rand(len);
      run_frame($sformatf("rnd%0d", n), 0, er_at);
    end

    make_inc(100);
    send_frame(0, -1, 40);
    exp_pkt[0] = 0; exp_pkt[1] = 0; exp_drop[0] = 0; exp_drop[1] = 0;
    check_out("rst_mid", 1'b0);
    make_rand(64);
    run_frame("after_rst", 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
